// File: rtl/fluid_channel_arbiter.sv
// Round-robin arbiter sharing one microfluidic read/write channel among NUM_REQ agents.
// Each transfer: start pulse, wait for chan_done (bounded by a timeout), then a valve settle after writes.
//
// state  | meaning
// IDLE   | no transfer; arbitrate pending requests
// ACCESS | transfer in flight, waiting for chan_done or timeout
// SETTLE | valve settle period after a completed write
// HOLD   | unreachable; recovers to IDLE
module fluid_channel_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 200,
    parameter int SETTLE_CYCLES  = 16
) (
    input  logic               sm_clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_wr,
    input  logic               chan_done,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               chan_start,
    output logic               chan_write,
    output logic               busy,
    output logic               settling,
    output logic               timeout_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        SETTLE = 2'b11,
        HOLD   = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [ID_W-1:0]    rr_ptr, rr_next;
    logic [NUM_REQ-1:0] grant_next;
    logic [ID_W-1:0]    id_next;
    logic               wr_next;
    logic               start_next;
    logic               tout_next;

    logic               found;
    logic [ID_W-1:0]    sel_id;
    logic [ID_W:0]      cand;

    // Search upward from the last grantee, wrapping, so the previous winner goes last.
    always_comb begin
        found  = 1'b0;
        sel_id = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ))
                cand = cand - (ID_W+1)'(NUM_REQ);
            if (!found && req[cand[ID_W-1:0]]) begin
                found  = 1'b1;
                sel_id = cand[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge sm_clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rr_ptr      <= ID_W'(NUM_REQ - 1);
            grant       <= '0;
            grant_id    <= '0;
            chan_write  <= 1'b0;
            chan_start  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            rr_ptr      <= rr_next;
            grant       <= grant_next;
            grant_id    <= id_next;
            chan_write  <= wr_next;
            chan_start  <= start_next;
            timeout_err <= tout_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rr_next    = rr_ptr;
        grant_next = grant;
        id_next    = grant_id;
        wr_next    = chan_write;
        start_next = 1'b0;
        tout_next  = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = ACCESS;
                    grant_next = NUM_REQ'(1) << sel_id;
                    id_next    = sel_id;
                    wr_next    = req_wr[sel_id];
                    start_next = 1'b1;
                    cnt_next   = '0;
                    rr_next    = sel_id;
                end
            end
            ACCESS: begin
                // A completion in the last allowed cycle still counts as success.
                if (chan_done) begin
                    grant_next = '0;
                    cnt_next   = '0;
                    state_next = chan_write ? SETTLE : IDLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    grant_next = '0;
                    cnt_next   = '0;
                    tout_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                grant_next = '0;
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        busy     = (state == ACCESS) || (state == SETTLE);
        settling = (state == SETTLE);
    end

endmodule

// File: tb/tb_fluid_channel_arbiter.sv
// Transaction-level bench: a reference model predicts grantee, transfer length and settle window.
module tb_fluid_channel_arbiter;

    localparam int NUM_REQ        = 4;
    localparam int ID_W           = 2;
    localparam int CNT_W          = 8;
    localparam int TIMEOUT_CYCLES = 200;
    localparam int SETTLE_CYCLES  = 16;

    logic               sm_clock;
    logic               reset;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] req_wr;
    logic               chan_done;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               chan_start;
    logic               chan_write;
    logic               busy;
    logic               settling;
    logic               timeout_err;

    int checks = 0;
    int errors = 0;
    int exp_last;

    fluid_channel_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES)
    ) dut (
        .sm_clock(sm_clock), .reset(reset), .req(req), .req_wr(req_wr),
        .chan_done(chan_done), .grant(grant), .grant_id(grant_id),
        .chan_start(chan_start), .chan_write(chan_write), .busy(busy),
        .settling(settling), .timeout_err(timeout_err)
    );

    initial begin
        sm_clock = 1'b0;
        forever #5 sm_clock = ~sm_clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_grant_id"}, 32'(grant_id), 0);
        chk({tag, "_start"}, 32'(chan_start), 0);
        chk({tag, "_write"}, 32'(chan_write), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_settling"}, 32'(settling), 0);
        chk({tag, "_timeout"}, 32'(timeout_err), 0);
    endtask

    // One transfer, entered and left at a falling edge. done_at < 0 means no completion.
    task automatic run_txn(input logic [NUM_REQ-1:0] rv, input logic [NUM_REQ-1:0] wv,
                           input int done_at);
        int exp_id;
        int last_j;
        logic exp_wr;
        exp_id = -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int c;
            c = (exp_last + k) % NUM_REQ;
            if (exp_id < 0 && rv[c]) exp_id = c;
        end
        exp_wr = wv[exp_id];
        last_j = (done_at < 0) ? TIMEOUT_CYCLES - 1 : done_at;

        req = rv; req_wr = wv; chan_done = 1'b0;
        @(negedge sm_clock);
        for (int j = 0; j <= last_j; j++) begin
            chk("acc_grant", 32'(grant), 32'(1) << exp_id);
            chk("acc_start", 32'(chan_start), (j == 0) ? 1 : 0);
            chk("acc_busy", 32'(busy), 1);
            chk("acc_timeout", 32'(timeout_err), 0);
            if (j == 0 || j == last_j) begin
                chk("acc_grant_id", 32'(grant_id), 32'(exp_id));
                chk("acc_write", 32'(chan_write), 32'(exp_wr));
                chk("acc_settling", 32'(settling), 0);
            end
            req = NUM_REQ'($urandom);
            req_wr = NUM_REQ'($urandom);
            chan_done = (j == done_at);
            if (j == last_j) req = '0;
            @(negedge sm_clock);
        end
        chan_done = 1'b0;
        chk("end_grant", 32'(grant), 0);
        if (done_at < 0) begin
            chk("to_pulse", 32'(timeout_err), 1);
            chk("to_busy", 32'(busy), 0);
            chk("to_settling", 32'(settling), 0);
            @(negedge sm_clock);
            chk("to_pulse_end", 32'(timeout_err), 0);
            chk("to_idle_grant", 32'(grant), 0);
        end else if (exp_wr) begin
            for (int s = 0; s < SETTLE_CYCLES; s++) begin
                chk("st_settling", 32'(settling), 1);
                chk("st_busy", 32'(busy), 1);
                chk("st_grant", 32'(grant), 0);
                chk("st_grant_id", 32'(grant_id), 32'(exp_id));
                chk("st_timeout", 32'(timeout_err), 0);
                req = (s == 0) ? '1 : NUM_REQ'($urandom);
                chan_done = 1'($urandom);
                if (s == SETTLE_CYCLES - 1) begin
                    req = '0;
                    chan_done = 1'b0;
                end
                @(negedge sm_clock);
            end
            chk("post_st_settling", 32'(settling), 0);
            chk("post_st_busy", 32'(busy), 0);
        end else begin
            chk("rd_busy", 32'(busy), 0);
            chk("rd_settling", 32'(settling), 0);
            chk("rd_timeout", 32'(timeout_err), 0);
        end
        exp_last = exp_id;
    endtask

    initial begin
        int r;
        int d;
        reset = 1'b0;
        req = '0; req_wr = '0; chan_done = 1'b0;
        exp_last = NUM_REQ - 1;

        for (int i = 0; i < 4; i++) begin
            req = NUM_REQ'($urandom);
            req_wr = NUM_REQ'($urandom);
            chan_done = 1'($urandom);
            @(negedge sm_clock);
            chk_quiet("rst");
        end

        req = '0; req_wr = '0; chan_done = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge sm_clock);
            chk("idle_grant", 32'(grant), 0);
            chk("idle_busy", 32'(busy), 0);
        end

        run_txn(4'b0100, 4'b0000, 3);
        run_txn(4'b0001, 4'b0001, 2);
        run_txn(4'b1111, 4'b0000, 1);

        for (int i = 0; i < 5; i++) run_txn(4'b1111, 4'b0000, 1);
        for (int i = 0; i < 4; i++) run_txn(4'b1101, 4'b0000, 1);

        run_txn(4'b1000, 4'b0000, -1);
        run_txn(4'b1000, 4'b0000, TIMEOUT_CYCLES - 1);
        run_txn(4'b1000, 4'b1000, 0);

        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0) d = TIMEOUT_CYCLES - 1;
            else if (r == 1) d = -1;
            else d = $urandom_range(0, 5);
            run_txn(NUM_REQ'($urandom_range(1, 15)), NUM_REQ'($urandom), d);
        end

        // Asynchronous reset during ACCESS
        req = 4'b1000; req_wr = 4'b1000;
        @(negedge sm_clock);
        chk("pre_rst_acc_busy", 32'(busy), 1);
        #2 reset = 1'b0;
        #1 chk_quiet("arst_acc");
        @(negedge sm_clock);
        req = '0; req_wr = '0;
        reset = 1'b1;
        exp_last = NUM_REQ - 1;
        run_txn(4'b1111, 4'b0000, 0);

        // Asynchronous reset during SETTLE
        req = 4'b0010; req_wr = 4'b0010;
        @(negedge sm_clock);
        req = '0;
        chan_done = 1'b1;
        @(negedge sm_clock);
        chan_done = 1'b0;
        chk("pre_rst_st_settling", 32'(settling), 1);
        @(negedge sm_clock);
        @(negedge sm_clock);
        #2 reset = 1'b0;
        #1 chk_quiet("arst_st");
        @(negedge sm_clock);
        req = '0; req_wr = '0;
        reset = 1'b1;
        exp_last = NUM_REQ - 1;
        run_txn(4'b1111, 4'b0000, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fluid_channel_arbiter.md
Name: fluid_channel_arbiter

Overview:
- Shares one microfluidic read/write access channel among NUM_REQ requesters.
- Requesters are the sensor-read and valve/pump-write agents; the channel is the idle/read/write/wait handshake state machine already in the design.
- Grants are round-robin; each transfer is sequenced as start, wait for done, then a valve settle period after writes.
- A hung channel is released by a timeout.

Parameters:
- NUM_REQ, 4, number of requesters (2..2^ID_W).
- ID_W, 2, width of grant_id.
- CNT_W, 8, width of the shared access/settle counter.
- TIMEOUT_CYCLES, 200, maximum ACCESS-state cycles before forced release (1..2^CNT_W-1).
- SETTLE_CYCLES, 16, cycles held in SETTLE after a completed write (1..2^CNT_W-1).

Ports:
- sm_clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = in reset.
- req  in  NUM_REQ  per-requester access request, level.
- req_wr  in  NUM_REQ  per-requester direction (1 = write, 0 = read); sampled with req at grant.
- chan_done  in  1  channel completion, 1-cycle pulse.
- grant  out  NUM_REQ  one-hot grant, registered.
- grant_id  out  ID_W  binary index of the current/last grantee.
- chan_start  out  1  1-cycle start pulse to the channel.
- chan_write  out  1  latched direction of the current transfer.
- busy  out  1  high in ACCESS or SETTLE.
- settling  out  1  high in SETTLE.
- timeout_err  out  1  1-cycle pulse on forced release.

Behaviour:
- Reset: asynchronous and active-low. While reset=0, all of the following hold:
  - state=IDLE; grant=0, grant_id=0, chan_start=0, chan_write=0, busy=0, settling=0, timeout_err=0; counter=0.
  - rr pointer = NUM_REQ-1, so req[0] has first priority.
  - Reset asserted mid-ACCESS or mid-SETTLE aborts immediately; no pulse is emitted.
- States (2-bit encoding): IDLE=00, ACCESS=01, SETTLE=11, HOLD=10 (unreachable; returns to IDLE next cycle).
- IDLE:
  - Grant nothing. On any req bit set at edge k, select the first set bit searching upward (with wrap) from rr pointer+1.
  - On that edge: grant, grant_id and chan_write=req_wr[i] are registered; chan_start=1; counter cleared; rr pointer=i; state goes to ACCESS.
  - Latency: req visible before edge k gives grant in the cycle after edge k; no grant in the same cycle as the request.
- ACCESS:
  - grant, grant_id and chan_write are held stable.
  - chan_start is high only in the first ACCESS cycle.
  - Counter increments each cycle.
  - Changes on req/req_wr are ignored, including the grantee dropping its req.
  - chan_done=1, read transfer: next state IDLE, grant cleared.
  - chan_done=1, write transfer: next state SETTLE, grant cleared, counter cleared, settling=1.
  - No chan_done while counter==TIMEOUT_CYCLES-1: timeout_err=1 for the next cycle, grant cleared, next state IDLE with no settle. ACCESS therefore lasts at most TIMEOUT_CYCLES cycles.
  - chan_done in the timeout cycle: done wins and timeout_err stays 0.
  - chan_done in the first ACCESS cycle (same cycle as chan_start) is accepted.
- SETTLE:
  - grant=0, busy=1, settling=1 for exactly SETTLE_CYCLES cycles, then IDLE.
  - Requests arriving here are held off; they are arbitrated in IDLE.
  - grant_id keeps the last grantee.
- chan_done in IDLE or SETTLE is ignored.
- Back-to-back transfers: the minimum gap between a read completion and the next chan_start is 1 IDLE cycle.
- Fairness: a requester that is continuously asserting waits at most NUM_REQ-1 transfers.
- Counter is CNT_W bits and never wraps; it saturates by construction of the bounds.

Test Plan:
- Reset values: reset=0 with random inputs -> all outputs 0. Release reset with req=0 -> stays IDLE, grant=0 for 10 cycles.
- Single read: req=0100, req_wr=0, chan_done pulsed 3 cycles after chan_start.
  - grant=0100 and grant_id=2 the cycle after the request edge; chan_start 1 cycle; chan_write=0.
  - grant drops the cycle after done; busy=0; settling never asserts.
- Write with settle: req=0001, req_wr=0001, done after 2 cycles.
  - settling=1 for exactly 16 cycles with grant=0, even with req=1111 during SETTLE.
  - Next grant=0010 after SETTLE (pointer at 0).
- Round-robin: req=1111 held, reads, done 1 cycle after each start -> grant order 0,1,2,3,0. Drop req[1] -> order 2,3,0,2.
- Timeout: req=1000, chan_done never pulsed -> ACCESS lasts 200 cycles, timeout_err 1-cycle pulse, grant cleared, no SETTLE. Repeat with done in cycle 200 -> no timeout_err.
- Async reset mid-operation: reset=0 driven between clock edges during ACCESS and during SETTLE -> outputs 0 immediately without waiting for sm_clock. After release, req=1111 -> grant=0001.
